// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the execute-stage ALU.
// Fixed 34-cycle start-to-done latency for every opcode.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [4:0]      AluControl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        op_q, op_d;
    logic [XLEN-1:0]   ma_q, ma_d;
    logic [XLEN-1:0]   mb_q, mb_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              signed_a, signed_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, mul_add;
    logic [XLEN:0]     div_trial, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    always_comb begin
        signed_a = (AluControl == OP_MULH) || (AluControl == OP_MULHSU) ||
                   (AluControl == OP_DIV)  || (AluControl == OP_REM);
        signed_b = (AluControl == OP_MULH) ||
                   (AluControl == OP_DIV)  || (AluControl == OP_REM);
    end

    assign mag_a = (signed_a && a[XLEN-1]) ? -a : a;
    assign mag_b = (signed_b && b[XLEN-1]) ? -b : b;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, ma_q};
    assign mul_add = acc_q[0] ? mul_sum : {1'b0, acc_q[2*XLEN-1:XLEN]};

    assign div_trial = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    assign div_diff  = div_trial - {1'b0, mb_q};

    assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo_fix  = (mb_q == '0) ? '1 :
                      ((sa_q ^ sb_q) ? -quo_q : quo_q);
    // With a zero divisor the signed magnitude path rebuilds the dividend.
    assign rem_fix  = (mb_q == '0) ? (sa_q ? -ma_q : ma_q) :
                      (sa_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0]);

    always_comb begin
        fix_val = '0;
        case (op_q)
            OP_MUL:    fix_val = prod_fix[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  fix_val = prod_fix[2*XLEN-1:XLEN];
            OP_DIV,
            OP_DIVU:   fix_val = quo_fix;
            OP_REM,
            OP_REMU:   fix_val = rem_fix;
            default:   fix_val = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    op_d    = AluControl;
                    ma_d    = mag_a;
                    mb_d    = mag_b;
                    sa_d    = signed_a & a[XLEN-1];
                    sb_d    = signed_b & b[XLEN-1];
                    acc_d   = {{XLEN{1'b0}}, mag_b};
                    rem_d   = '0;
                    quo_d   = mag_a;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = {mul_add, acc_q[XLEN-1:1]};
                    if (!div_diff[XLEN]) begin
                        rem_d = div_diff;
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = div_trial;
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1))
                        state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_val;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic
// reference model of the RV32M operations.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        kill;
    logic [4:0]  AluControl;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] last_exp;

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    muldiv_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .kill       (kill),
        .AluControl (AluControl),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [4:0] op,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx, sy, ux, uy, p;
        int ix, iy;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        ix = $signed(x);
        iy = $signed(y);
        case (op)
            OP_MUL:    begin p = ux * uy; return p[31:0];  end
            OP_MULH:   begin p = sx * sy; return p[63:32]; end
            OP_MULHSU: begin p = sx * uy; return p[63:32]; end
            OP_MULHU:  begin p = ux * uy; return p[63:32]; end
            OP_DIV: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    return 32'h8000_0000;
                return 32'(ix / iy);
            end
            OP_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            OP_REM: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    return 32'd0;
                return 32'(ix % iy);
            end
            OP_REMU:   return (y == 0) ? x : x % y;
            default:   return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Called #1 after a clock edge with the unit idle.
    task automatic do_op(input logic [4:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input bit kill_done,
                         input string tag);
        logic [31:0] exp;
        int lat;
        bit busy_ok;
        exp = model(op, av, bv);
        AluControl = op;
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        AluControl = 5'($urandom);
        lat = 0;
        busy_ok = busy;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (done) lat = k;
            else if (!busy) busy_ok = 1'b0;
        end
        check({tag, " latency"}, lat, 33);
        check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " result"}, result, exp);
        if (kill_done) begin
            kill = 1'b1;
            #1;
            check({tag, " done under kill"}, {31'd0, done}, 32'd1);
        end
        @(posedge clk);
        #1;
        kill = 1'b0;
        check({tag, " done drop"}, {31'd0, done}, 32'd0);
        check({tag, " idle"}, {31'd0, busy}, 32'd0);
        check({tag, " held"}, result, exp);
        last_exp = exp;
    endtask

    task automatic do_abort(input logic [4:0] op, input logic [31:0] av,
                            input logic [31:0] bv, input int k,
                            input bit use_reset, input string tag);
        AluControl = op;
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (k - 1) @(posedge clk);
        #1;
        if (use_reset) reset = 1'b1;
        else kill = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        kill = 1'b0;
        if (use_reset) last_exp = 32'd0;
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " result"}, result, last_exp);
    endtask

    initial begin
        int dones;
        int q[$];
        logic [4:0] ops[8];
        logic [4:0] op;
        logic [31:0] ra, rb;

        ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        reset = 1'b1;
        start = 1'b0;
        kill = 1'b0;
        AluControl = '0;
        a = '0;
        b = '0;
        last_exp = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);

        dones = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        check("idle quiet", dones, 0);

        do_op(OP_MUL,    32'hFFFF_FFFE, 32'd3, 1'b0, "mul");
        do_op(OP_MULH,   32'hFFFF_FFFE, 32'd3, 1'b0, "mulh");
        do_op(OP_MULHU,  32'hFFFF_FFFE, 32'd3, 1'b0, "mulhu");
        do_op(OP_MULHSU, 32'hFFFF_FFFE, 32'd3, 1'b0, "mulhsu");
        do_op(OP_DIV,    32'hFFFF_FFF9, 32'd2, 1'b0, "div");
        do_op(OP_REM,    32'hFFFF_FFF9, 32'd2, 1'b0, "rem");
        do_op(OP_DIVU,   32'hFFFF_FFF9, 32'd2, 1'b0, "divu");
        do_op(OP_REMU,   32'hFFFF_FFF9, 32'd2, 1'b1, "remu");
        do_op(OP_DIV,    32'd5, 32'd0, 1'b0, "div0");
        do_op(OP_REMU,   32'd5, 32'd0, 1'b0, "remu0");
        do_op(OP_REM,    32'hFFFF_FFFB, 32'd0, 1'b0, "rem0");
        do_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div ovf");
        do_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem ovf");
        do_op(5'b00011,  32'd7, 32'd9, 1'b0, "unknown op");

        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 5'($urandom) :
                 ops[$urandom_range(0, 7)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(op, ra, rb, 1'b0, "random");
        end

        kill = 1'b1;
        start = 1'b1;
        AluControl = OP_MUL;
        @(posedge clk);
        #1;
        kill = 1'b0;
        start = 1'b0;
        check("kill blocks start", {31'd0, busy}, 32'd0);

        AluControl = OP_MULHU;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        start = 1'b1;
        for (int c = 1; c <= 110; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                q.push_back(c);
                check("held start result", result,
                      model(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678));
            end
        end
        start = 1'b0;
        for (int c = 0; c < 40 && busy; c++) begin
            @(posedge clk);
            #1;
        end
        check("held start idle", {31'd0, busy}, 32'd0);
        check("held start count", q.size(), 3);
        if (q.size() == 3) begin
            check("held start first", q[0], 34);
            check("held start gap1", q[1] - q[0], 35);
            check("held start gap2", q[2] - q[1], 35);
        end
        last_exp = model(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);

        do_abort(OP_DIV, 32'd1000, 32'd7, 10, 1'b0, "kill calc");
        do_op(OP_DIV, 32'hFFFF_F000, 32'd7, 1'b0, "after kill");
        do_abort(OP_MUL, 32'd12345, 32'd678, 33, 1'b0, "kill fix");
        do_abort(OP_REM, 32'd1000, 32'd7, 20, 1'b1, "reset calc");
        do_op(OP_REM, 32'hFFFF_F000, 32'd7, 1'b0, "after reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
